irrigation_scheduler: RTL
=========================

Name: irrigation_scheduler

Overview:
Sequences the shared water path between tank refill (supply valve) and irrigation (sprinkler pump or dripper valve), so at most one actuator is on at any time. It filters the raw level and climate sensors, enforces minimum-on and cooldown dwell times on a slow tick, latches the irrigation mode per cycle, and raises the alarm on sensor conflict. It sits between the raw sensor pins and the actuator and LED outputs of the top level, and replaces the free-running combinational valve and alarm logic.

Parameters:
FILTER_TICKS, 2, consecutive equal sampled ticks before a filtered sensor value updates
MIN_ON_TICKS, 8, minimum ticks an irrigation actuator stays on
COOLDOWN_TICKS, 4, ticks with all actuators off after any actuation or fault
MAX_ON_TICKS, 60, watchdog limit in ticks (used only with the optional feature)
TIMER_W, 8, dwell timer width; MAX_ON_TICKS and MIN_ON_TICKS must each be < 2^TIMER_W

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-clock timebase strobe from the clock divider
low_water_level  in  1  raw; 1 = water at low sensor
mid_water_level  in  1  raw; 1 = water at mid sensor
high_water_level  in  1  raw; 1 = water at high sensor
earth_humidity  in  1  raw; 1 = soil wet
air_humidity  in  1  raw; 1 = air humid
low_temperature  in  1  raw; 1 = cold
water_supply_valvule  out  1  refill valve
splinker_bomb  out  1  sprinkler pump
dripper_valvule  out  1  dripper valve
alarm  out  1  fault or tank below low sensor
state  out  3  encoded state for the LED display
cycle_count  out  3  completed irrigation cycles, modulo 8
watchdog_trip  out  1  sticky watchdog flag

Behaviour:
- Reset is asynchronous. On reset: all actuators 0, alarm 0, state IDLE, cycle_count 0, watchdog_trip 0, timer 0, filtered sensors 0, filter_valid 0.
- Input path: every raw input passes through a 2-flop synchroniser. Each filter samples on tick only. A filtered value updates after FILTER_TICKS consecutive tick samples that agree.
- filter_valid sets FILTER_TICKS ticks after reset. While filter_valid is 0 the FSM holds in IDLE.
- conflict = (filtered high and not mid) or (filtered mid and not low).
- refill_req = not mid. irr_req = not earth_humidity and low.
- The mode is latched when IRRIGATE is entered. Sprinkler when air_humidity=0, low_temperature=0 and mid=1; dripper otherwise. The mode does not change until the cycle ends.
- State encodings: IDLE=0, REFILL=1, IRRIGATE=2, COOLDOWN=3, FAULT=4. The state output is the registered state.
- The timer clears on every state change. It increments on tick and saturates at all ones.
- IDLE transitions, first match wins:
  - conflict -> FAULT
  - low=0 and refill_req -> REFILL (the refill has priority when the tank is empty)
  - irr_req -> IRRIGATE
  - refill_req -> REFILL
- REFILL: water_supply_valvule=1. conflict -> FAULT. high=1 -> COOLDOWN.
- IRRIGATE: the latched actuator = 1. Exits, first match wins:
  - conflict -> FAULT
  - low=0 -> COOLDOWN immediately, ignoring MIN_ON (dry run protection)
  - earth_humidity=1 and timer >= MIN_ON_TICKS -> COOLDOWN
- cycle_count increments by 1 on every IRRIGATE->COOLDOWN transition, including the low-level exit. It wraps from 7 to 0. It does not increment on an exit to FAULT.
- COOLDOWN: all actuators 0. conflict -> FAULT. timer == COOLDOWN_TICKS -> IDLE.
- FAULT: all actuators 0. Leave to COOLDOWN on the first tick on which conflict=0.
- All actuator outputs are registered and are decoded from the next state. Actuators change on the same clock edge as the state change, and at most one actuator is ever 1.
- alarm is registered. It equals (next state == FAULT) or (filtered low == 0 and filter_valid).
- Transitions are evaluated on every clock, but the timer and filters advance only on tick. The conflict check has priority over every other transition in every state.
- If an exit condition and the start of a new request occur together, the FSM passes through COOLDOWN first. There is no direct REFILL<->IRRIGATE transition.

Optional Feature:
- Macro: IRRIGATION_WATCHDOG_EN.
- When defined: in REFILL or IRRIGATE, timer == MAX_ON_TICKS forces COOLDOWN and sets watchdog_trip. The flag stays set until reset. While it is set, alarm is also 1. A watchdog exit from IRRIGATE still increments cycle_count.
- When undefined: there is no time limit, watchdog_trip is tied to 0, and MAX_ON_TICKS is unused.

Test Plan:
1. Reset, then levels low=1, mid=1, high=0, earth=0, air=0, temp=0, ticks every 4 clocks. Expected: after the filter delay, state=2 and splinker_bomb=1. With earth=1 at tick 3, the pump stays on until timer=8, then COOLDOWN for 4 ticks, then IDLE, and cycle_count=1.
2. In IRRIGATE, drive low=0. Expected: COOLDOWN within FILTER_TICKS+sync delay, ignoring MIN_ON; dripper_valvule/splinker_bomb=0, alarm=1, cycle_count incremented.
3. From IDLE with low=1, mid=0, high=0 and earth=1. Expected: REFILL with water_supply_valvule=1. Set mid=1, high=1: COOLDOWN, valve=0.
4. Drive high=1, mid=0 (conflict) during REFILL. Expected: FAULT, all actuators 0, alarm=1, state=4. Clear the conflict: COOLDOWN, then IDLE.
5. Run 8 irrigation cycles. Expected: cycle_count wraps 7->0. Assert reset mid-IRRIGATE: all outputs 0 asynchronously, before the next clock edge.
6. With IRRIGATION_WATCHDOG_EN defined and MAX_ON_TICKS=60, hold earth=0. Expected: forced COOLDOWN at tick 60 with watchdog_trip=1 and alarm=1. watchdog_trip stays set until reset.

Source files
------------

// File: rtl/irrigation_scheduler.sv
// Water-path scheduler: filters raw level/climate sensors and sequences refill vs irrigation with dwell timers.
// Optional watchdog on actuation time: define IRRIGATION_WATCHDOG_EN.
module irrigation_scheduler #(
  parameter int FILTER_TICKS   = 2,
  parameter int MIN_ON_TICKS   = 8,
  parameter int COOLDOWN_TICKS = 4,
  parameter int MAX_ON_TICKS   = 60,
  parameter int TIMER_W        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       low_water_level,
  input  logic       mid_water_level,
  input  logic       high_water_level,
  input  logic       earth_humidity,
  input  logic       air_humidity,
  input  logic       low_temperature,
  output logic       water_supply_valvule,
  output logic       splinker_bomb,
  output logic       dripper_valvule,
  output logic       alarm,
  output logic [2:0] state,
  output logic [2:0] cycle_count,
  output logic       watchdog_trip
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REFILL   = 3'd1,
    S_IRRIGATE = 3'd2,
    S_COOLDOWN = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  localparam int NSENS = 6;
  localparam int I_LOW = 0, I_MID = 1, I_HIGH = 2, I_EARTH = 3, I_AIR = 4, I_TEMP = 5;
  localparam int FV_W = $clog2(FILTER_TICKS + 1);
  localparam logic [TIMER_W-1:0] MIN_ON_T   = TIMER_W'(MIN_ON_TICKS);
  localparam logic [TIMER_W-1:0] COOLDOWN_T = TIMER_W'(COOLDOWN_TICKS);

  if (MIN_ON_TICKS >= 2**TIMER_W || MAX_ON_TICKS >= 2**TIMER_W ||
      COOLDOWN_TICKS >= 2**TIMER_W) begin : g_bad_timer_w
    $error("irrigation_scheduler: TIMER_W too narrow for the dwell parameters");
  end

  logic [NSENS-1:0]                   w_raw, r_sync1, r_sync2, r_filt;
  logic [NSENS-1:0][FILTER_TICKS-1:0] r_hist, w_hist_nxt;
  logic [FV_W-1:0]                    r_fv_cnt;
  logic                               r_filter_valid;
  state_t                             r_state, w_state_nxt;
  logic [TIMER_W-1:0]                 r_timer;
  logic                               r_mode_drip, w_mode_drip, w_new_mode_drip;
  logic                               w_conflict, w_wd_hit, w_wd_trip_nxt;
  logic                               r_supply, r_pump, r_drip, r_alarm, r_wd_trip;
  logic [2:0]                         r_cycle;

  assign w_raw = {low_temperature, air_humidity, earth_humidity,
                  high_water_level, mid_water_level, low_water_level};

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Sample history per sensor; newest sample enters at bit 0.
  always_comb begin
    w_hist_nxt = r_hist;
    for (int i = 0; i < NSENS; i++) begin
      w_hist_nxt[i] = FILTER_TICKS'({r_hist[i], r_sync2[i]});
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hist         <= '0;
      r_filt         <= '0;
      r_fv_cnt       <= '0;
      r_filter_valid <= 1'b0;
    end else if (tick) begin
      r_hist <= w_hist_nxt;
      for (int i = 0; i < NSENS; i++) begin
        if (&w_hist_nxt[i])       r_filt[i] <= 1'b1;
        else if (~|w_hist_nxt[i]) r_filt[i] <= 1'b0;
      end
      if (!r_filter_valid) begin
        r_fv_cnt <= r_fv_cnt + 1'b1;
        if (r_fv_cnt == FV_W'(FILTER_TICKS - 1)) r_filter_valid <= 1'b1;
      end
    end
  end

  assign w_conflict = (r_filt[I_HIGH] & ~r_filt[I_MID]) | (r_filt[I_MID] & ~r_filt[I_LOW]);

`ifdef IRRIGATION_WATCHDOG_EN
  localparam logic [TIMER_W-1:0] MAX_ON_T = TIMER_W'(MAX_ON_TICKS);
  assign w_wd_hit      = ((r_state == S_REFILL) || (r_state == S_IRRIGATE)) && (r_timer == MAX_ON_T);
  assign w_wd_trip_nxt = r_wd_trip | (w_wd_hit & ~w_conflict);
`else
  assign w_wd_hit      = 1'b0;
  assign w_wd_trip_nxt = 1'b0;
`endif

  // Sprinkler only in warm, dry air with the tank above mid; mode frozen for the whole cycle.
  assign w_new_mode_drip = ~(~r_filt[I_AIR] & ~r_filt[I_TEMP] & r_filt[I_MID]);
  assign w_mode_drip     = (r_state == S_IRRIGATE) ? r_mode_drip : w_new_mode_drip;

  // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_filter_valid) begin
          if (w_conflict)                            w_state_nxt = S_FAULT;
          else if (!r_filt[I_LOW] && !r_filt[I_MID]) w_state_nxt = S_REFILL;
          else if (!r_filt[I_EARTH] && r_filt[I_LOW]) w_state_nxt = S_IRRIGATE;
          else if (!r_filt[I_MID])                   w_state_nxt = S_REFILL;
        end
      end
      S_REFILL: begin
        if (w_conflict)          w_state_nxt = S_FAULT;
        else if (w_wd_hit)       w_state_nxt = S_COOLDOWN;
        else if (r_filt[I_HIGH]) w_state_nxt = S_COOLDOWN;
      end
      S_IRRIGATE: begin
        if (w_conflict)                                  w_state_nxt = S_FAULT;
        else if (!r_filt[I_LOW])                         w_state_nxt = S_COOLDOWN;
        else if (w_wd_hit)                               w_state_nxt = S_COOLDOWN;
        else if (r_filt[I_EARTH] && r_timer >= MIN_ON_T) w_state_nxt = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (w_conflict)                 w_state_nxt = S_FAULT;
        else if (r_timer == COOLDOWN_T) w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        if (tick && !w_conflict) w_state_nxt = S_COOLDOWN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Actuators decode the next state so they switch on the same edge as the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_mode_drip <= 1'b0;
      r_supply    <= 1'b0;
      r_pump      <= 1'b0;
      r_drip      <= 1'b0;
      r_alarm     <= 1'b0;
      r_cycle     <= '0;
      r_wd_trip   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)   r_timer <= '0;
      else if (tick && r_timer != '1) r_timer <= r_timer + 1'b1;
      r_mode_drip <= w_mode_drip;
      r_supply    <= (w_state_nxt == S_REFILL);
      r_pump      <= (w_state_nxt == S_IRRIGATE) && !w_mode_drip;
      r_drip      <= (w_state_nxt == S_IRRIGATE) && w_mode_drip;
      if (r_state == S_IRRIGATE && w_state_nxt == S_COOLDOWN) r_cycle <= r_cycle + 1'b1;
      r_wd_trip <= w_wd_trip_nxt;
      r_alarm   <= (w_state_nxt == S_FAULT) || (!r_filt[I_LOW] && r_filter_valid) || w_wd_trip_nxt;
    end
  end

  assign water_supply_valvule = r_supply;
  assign splinker_bomb        = r_pump;
  assign dripper_valvule      = r_drip;
  assign alarm                = r_alarm;
  assign state                = r_state;
  assign cycle_count          = r_cycle;
  assign watchdog_trip        = r_wd_trip;

endmodule
